// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I LSU: one request at a time, WAIT_STATES wait cycles, byte-lane stores, extended loads.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned or illegal-funct3 requests on rsp_err.
module dmem_responder #(
    parameter int ADDR_W      = 15,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [31:0]       mem [0:(2**ADDR_W)-1];

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W+1:0] r_addr;
    logic [2:0]        r_f3;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_do_access;
    logic              w_we;
    logic [ADDR_W+1:0] w_addr;
    logic [2:0]        w_f3;
    logic [31:0]       w_wdata;
    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_lane;
    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_misalign;
    logic              w_fault;
    logic              w_wr_en;
    logic [31:0]       w_wr_word;
    logic [31:0]       w_rdata_nxt;
    logic              w_err_nxt;
    logic              w_unused_addr;

    function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    res = {{24{b[7]}}, b};
            3'd1:    res = {{16{h[15]}}, h};
            3'd2:    res = word;
            3'd4:    res = {24'd0, b};
            3'd5:    res = {16'd0, h};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Half stores use only lane[1] and word stores ignore the lane, so unchecked accesses align down.
    function automatic logic [31:0] f_store(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] res;
        res = word;
        case (f3)
            3'd0: res[{lane, 3'b000} +: 8] = wd[7:0];
            3'd1: begin
                if (lane[1]) begin
                    res[31:16] = wd[15:0];
                end else begin
                    res[15:0] = wd[15:0];
                end
            end
            3'd2:    res = wd;
            default: res = word;
        endcase
        return res;
    endfunction

    assign w_unused_addr = ^req_addr[31:ADDR_W+2];
    assign req_ready     = reset && (r_state == S_IDLE);
    assign w_accept      = req_valid && req_ready;
    assign rsp_valid     = (r_state == S_RESP);
    assign rsp_rdata     = r_rdata;
    assign rsp_err       = r_err;

    // Access operands: live request inputs for a zero-wait access, latched copies otherwise.
    always_comb begin
        w_we        = r_we;
        w_addr      = r_addr;
        w_f3        = r_f3;
        w_wdata     = r_wdata;
        w_do_access = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_we        = req_we;
                w_addr      = req_addr[ADDR_W+1:0];
                w_f3        = req_funct3;
                w_wdata     = req_wdata;
                w_do_access = w_accept && (WAIT_STATES == 0);
            end
            S_WAIT:  w_do_access = (r_cnt == 4'd0);
            default: w_do_access = 1'b0;
        endcase
    end

    // Address decode, fault detection and next-cycle write/response values.
    always_comb begin
        w_idx     = w_addr[ADDR_W+1:2];
        w_lane    = w_addr[1:0];
        w_word    = mem[w_idx];
        w_illegal = w_we ? (w_f3 >= 3'd3) : ((w_f3 == 3'd3) || (w_f3 >= 3'd6));
`ifdef DMEM_MISALIGN_CHECK_EN
        w_misalign = ((w_f3[1:0] == 2'd1) && w_lane[0]) ||
                     ((w_f3[1:0] == 2'd2) && (w_lane != 2'd0));
        w_err_nxt  = w_illegal || w_misalign;
`else
        w_misalign = 1'b0;
        w_err_nxt  = 1'b0;
`endif
        w_fault     = w_illegal || w_misalign;
        w_wr_en     = w_do_access && w_we && !w_fault;
        w_wr_word   = f_store(w_word, w_lane, w_f3, w_wdata);
        w_rdata_nxt = (w_we || w_fault) ? 32'd0 : f_load(w_word, w_lane, w_f3);
    end

    // Storage array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[w_idx] <= w_wr_word;
        end
    end

    // Request FSM, request latch and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_f3    <= 3'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr[ADDR_W+1:0];
                        r_f3    <= req_funct3;
                        r_wdata <= req_wdata;
                        if (WAIT_STATES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_do_access) begin
                r_rdata <= w_rdata_nxt;
                r_err   <= w_err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances (WAIT_STATES 0, 1, 3, 4), lane table plus timing sequences.
module tb_dmem_responder;

    localparam logic [31:0] B   = 32'h3000_0100;
    localparam int          NV  = 20;
    localparam logic        MIS =
`ifdef DMEM_MISALIGN_CHECK_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        logic        pre_en;
        logic [31:0] pre_val;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_mem;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr [4];
    logic [31:0] req_wdata [4];
    logic [31:0] rsp_rdata [4];
    logic [2:0]  req_funct3 [4];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    vec_t        vecs [NV];

    // Index 0..3 -> WAIT_STATES 0, 1, 3, 4; index 1 uses the full 15-bit array.
    for (genvar g = 0; g < 4; g++) begin : gen_dut
        dmem_responder #(
            .ADDR_W     (g == 1 ? 15 : 8),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : (g == 2 ? 3 : 4)))
        ) u_dut (
            .clk       (clk),
            .reset     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_funct3(req_funct3[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] peek(input int k, input logic [14:0] idx);
        case (k)
            0:       return gen_dut[0].u_dut.mem[idx[7:0]];
            1:       return gen_dut[1].u_dut.mem[idx];
            2:       return gen_dut[2].u_dut.mem[idx[7:0]];
            default: return gen_dut[3].u_dut.mem[idx[7:0]];
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Present a request, wait for accept, scramble the inputs, then wait for rsp_valid.
    task automatic issue(input int k, input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, output int lat);
        int g;
        @(negedge clk);
        req_we[k] = we; req_addr[k] = addr; req_funct3[k] = f3; req_wdata[k] = wd;
        req_valid[k] = 1'b1;
        g = 0;
        while (!req_ready[k] && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) chk("accept_timeout", 32'(g), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_wdata[k] = ~wd;
        req_addr[k]  = addr ^ 32'h0000_0004;
        lat = 0;
        while (!rsp_valid[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid[k]) chk("rsp_timeout", 32'(rsp_valid[k]), 32'd1);
    endtask

    task automatic release_rsp(input int k);
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[k] = 1'b0;
    endtask

    task automatic preload(input int k, input logic [31:0] addr, input logic [31:0] val, input int exp_lat);
        int lat;
        issue(k, 1'b1, addr, 3'd2, val, lat);
        chk("preload_lat", 32'(lat), 32'(exp_lat));
        release_rsp(k);
    endtask

    initial begin
        int lat;
        int acc [2];
        int n, guard;
        vecs[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, B + 32'd0, 3'd2, 32'd0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 32'd0, 1'b0, B + 32'd0, 3'd1, 32'd0, 32'hFFFFBEEF, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 32'd0, 1'b0, B + 32'd2, 3'd1, 32'd0, 32'hFFFFDEAD, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 32'd0, 1'b0, B + 32'd1, 3'd0, 32'd0, 32'hFFFFFFBE, 1'b0, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 32'd0, 1'b0, B + 32'd3, 3'd0, 32'd0, 32'hFFFFFFDE, 1'b0, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 32'd0, 1'b0, B + 32'd2, 3'd5, 32'd0, 32'h0000DEAD, 1'b0, 32'hDEADBEEF};
        vecs[6]  = '{1'b0, 32'd0, 1'b0, B + 32'd0, 3'd4, 32'd0, 32'h000000EF, 1'b0, 32'hDEADBEEF};
        vecs[7]  = '{1'b0, 32'd0, 1'b0, B + 32'd3, 3'd4, 32'd0, 32'h000000DE, 1'b0, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 32'd0, 1'b0, B + 32'd0, 3'd5, 32'd0, 32'h0000BEEF, 1'b0, 32'hDEADBEEF};
        vecs[9]  = '{1'b1, 32'd0, 1'b1, B + 32'd1, 3'd0, 32'h12345678, 32'd0, 1'b0, 32'h00007800};
        vecs[10] = '{1'b0, 32'd0, 1'b1, B + 32'd2, 3'd1, 32'h12345678, 32'd0, 1'b0, 32'h56787800};
        vecs[11] = '{1'b0, 32'd0, 1'b1, B + 32'd0, 3'd2, 32'h12345678, 32'd0, 1'b0, 32'h12345678};
        vecs[12] = '{1'b1, 32'hAAAAAAAA, 1'b1, B + 32'd2, 3'd2, 32'h55555555, 32'd0, MIS,
                     MIS ? 32'hAAAAAAAA : 32'h55555555};
        vecs[13] = '{1'b1, 32'hDEADBEEF, 1'b0, B + 32'd1, 3'd1, 32'd0,
                     MIS ? 32'd0 : 32'hFFFFBEEF, MIS, 32'hDEADBEEF};
        vecs[14] = '{1'b0, 32'd0, 1'b0, B + 32'd0, 3'd3, 32'd0, 32'd0, MIS, 32'hDEADBEEF};
        vecs[15] = '{1'b1, 32'h11111111, 1'b1, B + 32'd0, 3'd3, 32'h22222222, 32'd0, MIS, 32'h11111111};
        vecs[16] = '{1'b1, 32'h0BADF00D, 1'b0, 32'h0000_0100, 3'd2, 32'd0, 32'h0BADF00D, 1'b0, 32'h0BADF00D};
        vecs[17] = '{1'b0, 32'd0, 1'b1, 32'h0000_0103, 3'd0, 32'h000000AB, 32'd0, 1'b0, 32'hABADF00D};
        vecs[18] = '{1'b0, 32'd0, 1'b0, B + 32'd0, 3'd7, 32'd0, 32'd0, MIS, 32'hABADF00D};
        vecs[19] = '{1'b0, 32'd0, 1'b0, B + 32'd2, 3'd2, 32'd0,
                     MIS ? 32'd0 : 32'hABADF00D, MIS, 32'hABADF00D};

        req_valid = 4'd0; req_we = 4'd0; rsp_ready = 4'd0;
        for (int k = 0; k < 4; k++) begin
            req_addr[k] = 32'd0; req_wdata[k] = 32'd0; req_funct3[k] = 3'd0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_rsp_valid%0d", k), 32'(rsp_valid[k]), 32'd0);
            chk($sformatf("rst_rdata%0d", k), rsp_rdata[k], 32'd0);
            chk($sformatf("rst_err%0d", k), 32'(rsp_err[k]), 32'd0);
            chk($sformatf("rst_req_ready%0d", k), 32'(req_ready[k]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) chk($sformatf("post_rst_ready%0d", k), 32'(req_ready[k]), 32'd1);

        // Lane table on the WAIT_STATES=1 instance.
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].pre_en) preload(1, B, vecs[i].pre_val, 1);
            issue(1, vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wdata, lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'd1);
            chk($sformatf("v%0d_rdata", i), rsp_rdata[1], vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(rsp_err[1]), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_mem", i), peek(1, 15'h40), vecs[i].exp_mem);
            release_rsp(1);
        end

        // Latency and backpressure, WAIT_STATES=3; a request held during RESP must not be taken.
        preload(2, B, 32'hCAFEF00D, 3);
        issue(2, 1'b0, B, 3'd2, 32'd0, lat);
        chk("bp_lat", 32'(lat), 32'd3);
        req_we[2] = 1'b1; req_addr[2] = B; req_funct3[2] = 3'd2; req_wdata[2] = 32'd0;
        req_valid[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", c), 32'(rsp_valid[2]), 32'd1);
            chk($sformatf("bp_rdata%0d", c), rsp_rdata[2], 32'hCAFEF00D);
            chk($sformatf("bp_ready%0d", c), 32'(req_ready[2]), 32'd0);
        end
        release_rsp(2);
        chk("bp_idle_valid", 32'(rsp_valid[2]), 32'd0);
        chk("bp_idle_ready", 32'(req_ready[2]), 32'd1);
        req_valid[2] = 1'b0;
        repeat (6) @(negedge clk);
        chk("bp_no_accept_mem", peek(2, 15'h40), 32'hCAFEF00D);
        chk("bp_no_accept_valid", 32'(rsp_valid[2]), 32'd0);

        // Reset during WAIT drops the pending store, WAIT_STATES=4.
        preload(3, B, 32'd0, 4);
        @(negedge clk);
        req_we[3] = 1'b1; req_addr[3] = B; req_funct3[3] = 3'd2; req_wdata[3] = 32'h55555555;
        req_valid[3] = 1'b1;
        chk("rw_accept_ready", 32'(req_ready[3]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[3] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_valid", 32'(rsp_valid[3]), 32'd0);
        chk("rw_ready_in_rst", 32'(req_ready[3]), 32'd0);
        @(negedge clk);
        chk("rw_mem_in_rst", peek(3, 15'h40), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rw_ready_after", 32'(req_ready[3]), 32'd1);
        repeat (6) @(negedge clk);
        chk("rw_mem_after", peek(3, 15'h40), 32'd0);
        chk("rw_valid_after", 32'(rsp_valid[3]), 32'd0);

        // Reset during RESP keeps the committed store, WAIT_STATES=0.
        issue(0, 1'b1, 32'h0000_000C, 3'd2, 32'h77777777, lat);
        chk("rr_lat", 32'(lat), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rr_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rr_mem", peek(0, 15'h3), 32'h77777777);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rr_ready_after", 32'(req_ready[0]), 32'd1);

        // Back-to-back SW then LW with rsp_ready held, WAIT_STATES=0.
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 32'h0000_0008; req_funct3[0] = 3'd2;
        req_wdata[0] = 32'hA5A55A5A; req_valid[0] = 1'b1;
        n = 0;
        guard = 0;
        acc[0] = 0;
        acc[1] = 0;
        while (n < 2 && guard < 20) begin
            if (req_ready[0]) begin
                acc[n] = cyc;
                n++;
                @(posedge clk);
                @(negedge clk);
                if (n == 1) begin
                    chk("b2b_st_valid", 32'(rsp_valid[0]), 32'd1);
                    chk("b2b_st_rdata", rsp_rdata[0], 32'd0);
                    req_we[0] = 1'b0; req_wdata[0] = 32'd0;
                end else begin
                    req_valid[0] = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
            guard++;
        end
        chk("b2b_accepts", 32'(n), 32'd2);
        chk("b2b_spacing", 32'(acc[1] - acc[0]), 32'd2);
        chk("b2b_ld_valid", 32'(rsp_valid[0]), 32'd1);
        chk("b2b_ld_rdata", rsp_rdata[0], 32'hA5A55A5A);
        chk("b2b_mem", peek(0, 15'h2), 32'hA5A55A5A);
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I MCU. It is the target end of the core's load/store interface. It accepts one LSU request at a time over a valid/ready handshake and inserts a configurable number of wait states. Stores are merged into the addressed word with byte lanes (SB/SH/SW). For loads it extracts, sign-extends or zero-extends the addressed lane (LB/LH/LW/LBU/LHU) and returns a registered response. It replaces the zero-latency RAM behind the core so that LSU stall handling can be exercised.

## Interface
- ADDR_W, 15: word-index width; the array holds 2**ADDR_W 32-bit words.
- WAIT_STATES, 1: extra cycles between request accept and the memory access (0..15).
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- req_valid  input  1  LSU request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; word index = req_addr[ADDR_W+1:2], upper bits ignored.
- req_funct3  input  3  RV32I load/store funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  LSU accepts response.
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or had an illegal funct3.

## Operation
- The storage array is named `mem` so the bench can reach it by backdoor. It is not reset.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/funct3/wdata.
    - If WAIT_STATES=0, perform the access on the same edge and go to RESP.
    - Otherwise go to WAIT with cnt=WAIT_STATES-1.
  - WAIT: req_ready=0. If cnt≠0, decrement. If cnt=0, perform the access on this edge and go to RESP.
  - RESP: rsp_valid=1, req_ready=0. On rsp_ready, go to IDLE.
- Access on an SB store: write byte lane addr[1:0] with wdata[7:0]; the other lanes are unchanged.
- Access on an SH store: write half lane addr[1] (bytes 0-1 or 2-3) with wdata[15:0].
- Access on an SW store: write the full word.
- Access on a load: select byte lane addr[1:0] or half lane addr[1].
  - LB/LH sign-extend the selected lane.
  - LBU/LHU zero-extend it.
  - LW returns the whole word.
- The load result is registered into rsp_rdata. Stores set rsp_rdata=0.
- Error cases (see Configuration):
  - misaligned half (addr[0]=1) or word (addr[1:0]≠0);
  - load funct3 ∈ {3,6,7};
  - store funct3 ≥3.
- On error: no write, rsp_rdata=0, rsp_err=1.
- rsp_rdata and rsp_err hold their values until the next access edge.

## Timing
- Reset values: state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready is forced 0 while reset is low.
- Latency: a request accepted on edge E gives rsp_valid=1 after edge E+WAIT_STATES (WAIT_STATES+1 cycles).
- The store becomes visible in `mem` on that same edge.
- rsp_valid stays high, with stable outputs, until an edge where rsp_ready=1. rsp_ready while rsp_valid=0 is ignored.
- Minimum spacing between accepts is WAIT_STATES+2 cycles. No new request is accepted in the cycle RESP completes; the next accept is the following cycle in IDLE.
- The request inputs are sampled only at the accept edge; later changes have no effect.
- Reset asserted in WAIT: the pending store is dropped and the FSM returns to IDLE immediately.
- Reset asserted in RESP: rsp_valid drops immediately, and the already-committed write remains in `mem`.
- Addresses with identical low ADDR_W+2 bits alias, e.g. 0x3000_0100 and 0x0000_0100 both hit word 0x40.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined: the misalignment and illegal-funct3 checks are active, and rsp_err behaves as described above.
- DMEM_MISALIGN_CHECK_EN undefined:
  - rsp_err is tied 0.
  - Halves ignore addr[0]; words ignore addr[1:0] (the access is aligned down).
  - An illegal load funct3 returns 0; an illegal store funct3 writes nothing.

## Test plan
- Load lanes: mem[0x40]=0xDEADBEEF, WAIT_STATES=1, with these addr 0x3000_0100 + offset loads, all rsp_err=0:
  - LW +0 → 0xDEADBEEF.
  - LH +0 → 0xFFFFBEEF; LH +2 → 0xFFFFDEAD.
  - LB +1 → 0xFFFFFFBE; LB +3 → 0xFFFFFFDE.
  - LHU +2 → 0x0000DEAD.
  - LBU +0 → 0x000000EF.
- Store lanes: mem[0x40]=0, wdata=0x12345678.
  - SB +1 → 0x00007800; then SH +2 → 0x56787800; then SW +0 → 0x12345678.
- Latency and backpressure: WAIT_STATES=3, accept on edge E → rsp_valid rises after E+3. Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stay stable and req_ready=0. Then rsp_ready=1 → IDLE on the next edge.
- Misalign (macro defined): SW addr 0x3000_0102 with mem[0x40]=0xAAAAAAAA → rsp_err=1 and mem unchanged. LH addr +1 → rsp_err=1, rsp_rdata=0. Macro undefined: same LH → 0xFFFFBEEF on DEADBEEF data, rsp_err=0.
- Reset mid-operation: WAIT_STATES=4, SW 0x55555555 accepted, reset low two cycles later → rsp_valid=0, mem word unchanged, req_ready=0 during reset and 1 after release.
- WAIT_STATES=0 back-to-back: SW then LW to the same address with rsp_ready held 1 → the LW returns the stored value, and accepts are spaced exactly 2 cycles apart.
